// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: state codes, frame shape
// and the odd-parity helper.
package rx_serial_pkg;

    localparam int N_DADOS  = 7;
    localparam int N_PARADA = 1;
    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    localparam logic PARIDADE_IMPAR = 1'b1;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        CONFIRMA = 4'd2,
        RECEBE   = 4'd3,
        PARIDADE = 4'd4,
        PARADA   = 4'd5,
        ARMAZENA = 4'd6,
        QUEBRA   = 4'd7
    } estado_t;

    function automatic logic paridade_correta(input logic [N_DADOS-1:0] dado,
                                              input logic               bit_par);
        return (^{dado, bit_par}) == PARIDADE_IMPAR;
    endfunction

endpackage

// File: rtl/rx_serial_7o1_tick_gen.sv
// Bit-timing counter: counts up to a selectable terminal value and pulses
// tick on the cycle it is reached, then wraps so consecutive bits stay aligned.
import rx_serial_pkg::*;

module rx_tick_gen #(
    parameter int M = 434,
    parameter int W = $clog2(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] ultimo,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic         fim;

    assign fim  = (cnt == ultimo);
    // tick deliberately ignores clear: the FSM raises clear in response to tick.
    assign tick = enable & fim;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= fim ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver: start bit, 7 data bits LSB first,
// odd parity, one stop bit; one-cycle pronto with parity/framing status.
import rx_serial_pkg::*;

module rx_serial_7o1 #(
    parameter int CICLOS_BIT = 434,
    parameter int META_BIT   = CICLOS_BIT / 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               entrada_serial,
    output logic [N_DADOS-1:0] dado_recebido,
    output logic               pronto,
    output logic               paridade_ok,
    output logic               erro_parada,
    output logic [3:0]         db_estado
);

    localparam int WT = $clog2(CICLOS_BIT);
    localparam int WB = $clog2(N_DADOS);
    localparam logic [WT-1:0] ULT_BIT   = WT'(CICLOS_BIT - 1);
    localparam logic [WT-1:0] ULT_META  = WT'(META_BIT - 1);
    localparam logic [WB-1:0] ULT_DADOS = WB'(N_DADOS - 1);

    estado_t estado, prox;

    logic [1:0]         sinc;
    logic               linha;
    logic [N_DADOS-1:0] desloc;
    logic [WB-1:0]      n_bits;
    logic               bit_par;
    logic               bit_parada;

    logic               limpa_tick;
    logic               conta;
    logic               sel_meta;
    logic               tick;
    logic               limpa_bits;
    logic               amostra_dado;
    logic               amostra_par;
    logic               amostra_parada;

    assign linha     = sinc[1];
    assign db_estado = estado;

    rx_tick_gen #(
        .M (CICLOS_BIT),
        .W (WT)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (limpa_tick),
        .enable (conta),
        .ultimo (sel_meta ? ULT_META : ULT_BIT),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox           = estado;
        limpa_tick     = 1'b0;
        conta          = 1'b0;
        sel_meta       = 1'b0;
        limpa_bits     = 1'b0;
        amostra_dado   = 1'b0;
        amostra_par    = 1'b0;
        amostra_parada = 1'b0;
        case (estado)
            INICIAL: prox = ESPERA;
            ESPERA: begin
                limpa_tick = 1'b1;
                limpa_bits = 1'b1;
                if (!linha) prox = CONFIRMA;
            end
            CONFIRMA: begin
                conta    = 1'b1;
                sel_meta = 1'b1;
                if (tick) begin
                    // A line back at 1 by mid-start-bit was only a glitch.
                    if (linha) begin
                        prox = ESPERA;
                    end else begin
                        prox       = RECEBE;
                        limpa_tick = 1'b1;
                    end
                end
            end
            RECEBE: begin
                conta = 1'b1;
                if (tick) begin
                    amostra_dado = 1'b1;
                    if (n_bits == ULT_DADOS) prox = PARIDADE;
                end
            end
            PARIDADE: begin
                conta = 1'b1;
                if (tick) begin
                    amostra_par = 1'b1;
                    prox        = PARADA;
                end
            end
            PARADA: begin
                conta = 1'b1;
                if (tick) begin
                    amostra_parada = 1'b1;
                    prox           = ARMAZENA;
                end
            end
            ARMAZENA: prox = bit_parada ? ESPERA : QUEBRA;
            // A line stuck low after a bad stop bit must go high before rearming.
            QUEBRA: if (linha) prox = ESPERA;
            default: prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc          <= 2'b11;
            desloc        <= '0;
            n_bits        <= '0;
            bit_par       <= 1'b0;
            bit_parada    <= 1'b0;
            dado_recebido <= '0;
            pronto        <= 1'b0;
            paridade_ok   <= 1'b0;
            erro_parada   <= 1'b0;
        end else begin
            sinc   <= {sinc[0], entrada_serial};
            pronto <= (estado == ARMAZENA);
            if (limpa_bits) begin
                n_bits <= '0;
            end else if (amostra_dado) begin
                desloc <= {linha, desloc[N_DADOS-1:1]};
                n_bits <= n_bits + 1'b1;
            end
            if (amostra_par)    bit_par    <= linha;
            if (amostra_parada) bit_parada <= linha;
            if (estado == ARMAZENA) begin
                dado_recebido <= desloc;
                paridade_ok   <= paridade_correta(desloc, bit_par);
                erro_parada   <= ~bit_parada;
            end
        end
    end

endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7O1

Overview:
- Asynchronous serial receiver: the receive end of the same 7O1 link whose transmitter drives saida_serial from the robot datapath.
- Accepts the frame start(0), 7 data bits LSB-first, odd parity, 1 stop(1).
- Delivers a 7-bit word with a one-cycle pronto pulse plus parity/framing status.
- Used to receive operator commands (e.g. ligar/desligar, sensor select) into the robot control unit.

Parameters:
- CICLOS_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); legal range 8 or more.
- META_BIT, CICLOS_BIT/2, sample offset from the start edge to mid-bit.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- entrada_serial  in  1  serial line; idles high.
- dado_recebido  out  7  last received word; holds until the next frame completes.
- pronto  out  1  one-cycle pulse when dado_recebido/status update.
- paridade_ok  out  1  1 = odd parity correct for the last frame.
- erro_parada  out  1  1 = stop bit sampled 0 in the last frame.
- db_estado  out  4  current FSM state code.

Behaviour:
- Reset (reset=0, async) forces:
  - FSM to INICIAL.
  - dado_recebido=0, pronto=0, paridade_ok=0, erro_parada=0, db_estado=0.
  - Shift register, bit counter and tick counter to 0.
- A reset asserted mid-frame aborts that frame; no pronto is produced.
- entrada_serial passes through a 2-FF synchronizer; all decisions use the synchronized value (2-cycle input latency).
- FSM states (db_estado code):
  - INICIAL(0): leaves after the first clock out of reset, to ESPERA.
  - ESPERA(1): idle. A synchronized 0 moves to CONFIRMA; the tick counter clears.
  - CONFIRMA(2): counts META_BIT cycles, then samples the line.
    - 1 = glitch: return to ESPERA with no output change.
    - 0 = valid start: go to RECEBE; tick counter clears.
  - RECEBE(3): every CICLOS_BIT cycles, samples one bit into the shift register, LSB first. After the 7th sample, go to PARIDADE.
  - PARIDADE(4): samples the parity bit after CICLOS_BIT cycles, then goes to PARADA.
  - PARADA(5): samples the stop bit after CICLOS_BIT cycles, then goes to ARMAZENA.
  - ARMAZENA(6): registers the outputs and asserts pronto for exactly one cycle:
    - dado_recebido <= shift register.
    - paridade_ok <= ^{data, parity} == 1.
    - erro_parada <= ~stop.
    - Next state: ESPERA if the stop bit was 1, otherwise QUEBRA.
  - QUEBRA(7): break/framing recovery. Waits until the synchronized line is 1, then goes to ESPERA. A low line held indefinitely never retriggers reception.
- Timing: pronto rises 2 cycles after the stop-bit sample instant.
  - From the falling start edge at the pin to pronto: 2 + META_BIT + 9*CICLOS_BIT + 2 cycles.
- Frames are accepted back-to-back: ESPERA is re-entered before the stop bit ends, so a start edge immediately after the stop bit is caught.
- Data and status are delivered even on a parity or stop error; the consumer checks the flags.
- Status flags and data change only in ARMAZENA and are otherwise held.
- entrada_serial changes between sample points are ignored; only mid-bit samples matter.

Decomposition:
- Shared package rx_serial_pkg:
  - FSM state encodings (4-bit, values above).
  - Frame constants: N_DADOS=7, odd parity, 1 stop bit.
- Sub-module rx_tick_gen: modulo-M counter with clear, enable and terminal-count pulse, parameterized by M. The FSM drives clear and selects between META_BIT and CICLOS_BIT.
- The synchronizer and shift register stay inline.

Test Plan (CICLOS_BIT=16):
- Word 0x35 (bits 1010110, 4 ones, parity=1), stop=1 -> pronto pulses once, dado_recebido=7'h35, paridade_ok=1, erro_parada=0, pulse at 2+8+144+2=156 cycles after start edge.
- Word 0x41 with parity bit 0 (wrong) -> dado_recebido=7'h41, paridade_ok=0, erro_parada=0.
- Word 0x7F, stop=0, line held low for 100 cycles then high -> pronto once, erro_parada=1, db_estado=7 while low, no second frame; a following 0x12 frame is received correctly.
- 5-cycle low glitch on an idle line -> return to ESPERA, no pronto, outputs unchanged.
- Three back-to-back frames 0x01, 0x55, 0x2A with no idle gap -> three pronto pulses, values in order, all paridade_ok=1.
- reset=0 asserted during bit 4 of a frame -> all outputs 0 immediately; after release, no pronto for the aborted frame; the next full frame 0x33 is received correctly.
